// File: rtl/boid_fb_scheduler.sv
// boid_fb_scheduler
// Per-frame framebuffer write sequencer for the boid display. On each
// frame_start pulse it first erases every boid pixel drawn last frame
// (BG_COLOR), then fetches each boid's new position from the position table
// and draws it (BOID_COLOR). Writes are held off while the display is in the
// active region, so scan-out reads never see a competing write.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   frame_start  one-cycle pulse at frame end
//   active       display in visible region; writes are stalled while high
//   boid_idx     position-table read index
//   boid_x/y     table data, valid the cycle after boid_idx is presented
//   fb_addr      framebuffer address   (0 when fb_wen=0)
//   fb_wdata     framebuffer data      (0 when fb_wen=0)
//   fb_wen       framebuffer write enable
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse when a frame sequence completes
//   overrun_cnt  saturating count of frame_start pulses dropped while busy
module boid_fb_scheduler #(
    parameter int NUM_BOIDS  = 16,
    parameter int IDX_W      = 4,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 9,
    parameter int BG_COLOR   = 31,
    parameter int BOID_COLOR = 42
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              active,
    output logic [IDX_W-1:0]  boid_idx,
    input  logic [9:0]        boid_x,
    input  logic [8:0]        boid_y,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_wdata,
    output logic              fb_wen,
    output logic              busy,
    output logic              done,
    output logic [7:0]        overrun_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_FETCH, S_WAIT, S_DRAW, S_DONE
    } state_t;

    localparam logic [9:0]       H_LIM    = 10'(H_RES);
    localparam logic [8:0]       V_LIM    = 9'(V_RES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BOIDS - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [9:0]             cap_x_q, cap_x_d;
    logic [8:0]             cap_y_q, cap_y_d;
    logic [9:0]             old_x_q [NUM_BOIDS];
    logic [9:0]             old_x_d [NUM_BOIDS];
    logic [8:0]             old_y_q [NUM_BOIDS];
    logic [8:0]             old_y_d [NUM_BOIDS];
    logic [NUM_BOIDS-1:0]   old_vld_q, old_vld_d;
    logic [7:0]             ovr_q, ovr_d;

    logic                   last;
    logic                   in_range;
    logic [ADDR_W-1:0]      erase_addr;
    logic [ADDR_W-1:0]      draw_addr;

    // Products are formed at full address width so row 479 does not truncate.
    assign erase_addr = ADDR_W'(old_y_q[idx_q]) * ADDR_W'(H_RES) + ADDR_W'(old_x_q[idx_q]);
    assign draw_addr  = ADDR_W'(cap_y_q) * ADDR_W'(H_RES) + ADDR_W'(cap_x_q);
    assign in_range   = (cap_x_q < H_LIM) && (cap_y_q < V_LIM);
    assign last       = (idx_q == LAST_IDX);

    assign boid_idx    = idx_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign overrun_cnt = ovr_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cap_x_d   = cap_x_q;
        cap_y_d   = cap_y_q;
        old_x_d   = old_x_q;
        old_y_d   = old_y_q;
        old_vld_d = old_vld_q;
        ovr_d     = ovr_q;
        fb_wen    = 1'b0;
        fb_addr   = '0;
        fb_wdata  = '0;

        // Any frame_start outside IDLE (DONE included) is dropped and counted.
        if (frame_start && (state_q != S_IDLE) && (ovr_q != 8'hFF))
            ovr_d = ovr_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (frame_start) state_d = S_ERASE;
            end
            S_ERASE: begin
                if (!active) begin
                    if (old_vld_q[idx_q]) begin
                        fb_wen   = 1'b1;
                        fb_addr  = erase_addr;
                        fb_wdata = DATA_W'(BG_COLOR);
                    end
                    if (last) begin
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                cap_x_d = boid_x;
                cap_y_d = boid_y;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (!active) begin
                    // Off-screen boids are remembered as invalid so next
                    // frame's erase skips them.
                    old_x_d[idx_q]   = cap_x_q;
                    old_y_d[idx_q]   = cap_y_q;
                    old_vld_d[idx_q] = in_range;
                    if (in_range) begin
                        fb_wen   = 1'b1;
                        fb_addr  = draw_addr;
                        fb_wdata = DATA_W'(BOID_COLOR);
                    end
                    if (last) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cap_x_q   <= '0;
            cap_y_q   <= '0;
            old_x_q   <= '{default: '0};
            old_y_q   <= '{default: '0};
            old_vld_q <= '0;
            ovr_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cap_x_q   <= cap_x_d;
            cap_y_q   <= cap_y_d;
            old_x_q   <= old_x_d;
            old_y_q   <= old_y_d;
            old_vld_q <= old_vld_d;
            ovr_q     <= ovr_d;
        end
    end

endmodule

// File: doc/boid_fb_scheduler.md
# boid_fb_scheduler

Per-frame write sequencer for the boid framebuffer (pixel-index RAM, 640x480, one palette index per pixel). On each frame-boundary pulse it erases every boid's previously drawn pixel with the background palette index, then fetches each boid's new position from the position table and draws it with the boid palette index. It owns the framebuffer write port and writes only while the display is outside the active region, so it never competes with scan-out reads.

## Interface
- NUM_BOIDS, 16, boids handled per frame (power of 2, 2..64)
- IDX_W, 4, log2(NUM_BOIDS)
- H_RES, 640, visible width
- V_RES, 480, visible height
- ADDR_W, 19, framebuffer address width
- DATA_W, 9, palette index width
- BG_COLOR, 31, background palette index
- BOID_COLOR, 42, boid palette index

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-low (0 = reset)
- frame_start  in  1  one-cycle pulse at frame end (clk domain)
- active  in  1  display in visible region; no writes while high
- boid_idx  out  IDX_W  position-table read index
- boid_x  in  10  table x; valid the cycle after boid_idx is presented
- boid_y  in  9  table y; same timing
- fb_addr  out  ADDR_W  framebuffer address
- fb_wdata  out  DATA_W  framebuffer write data
- fb_wen  out  1  framebuffer write enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at sequence completion
- overrun_cnt  out  8  saturating count of frame_start pulses dropped while busy

## Operation
- Internal old-position store: NUM_BOIDS entries of {x[9:0], y[8:0], valid}; every valid bit is cleared by reset.
- States: IDLE, ERASE, FETCH, WAIT, DRAW, DONE.
- IDLE: idx=0; frame_start -> ERASE.
- ERASE: one cycle per idx; if entry valid: fb_addr = old_y*H_RES + old_x, fb_wdata = BG_COLOR, fb_wen=1; invalid entry: fb_wen=0, still one cycle. After idx NUM_BOIDS-1: idx=0 -> FETCH.
- FETCH: boid_idx=idx -> WAIT. WAIT: capture boid_x/boid_y -> DRAW.
- DRAW: if x<H_RES and y<V_RES: fb_addr = y*H_RES + x, fb_wdata = BOID_COLOR, fb_wen=1, store {x,y,valid=1}; otherwise fb_wen=0, store valid=0. Last idx -> DONE, else idx+1 -> FETCH.
- DONE: done=1 for one cycle -> IDLE.
- All erases precede all draws, so a boid drawn onto another boid's old pixel is never erased.
- Address arithmetic is performed at ADDR_W bits; y*H_RES must not truncate (479*640+639 = 307199).
- Stall: in ERASE or DRAW with active=1, fb_wen=0 and the state, idx and store are held. FETCH/WAIT are not stalled.
- frame_start while busy: ignored, overrun_cnt+1 (saturates at 255). frame_start in the DONE cycle also counts as overrun.
- Reset mid-sequence: immediate return to IDLE, all outputs zero, store invalidated, overrun_cnt=0.

## Timing
- Reset values: boid_idx=0, fb_addr=0, fb_wdata=0, fb_wen=0, busy=0, done=0, overrun_cnt=0.
- fb_addr/fb_wdata/fb_wen are decoded from registered state; the RAM samples them at the rising edge ending the state cycle.
- fb_addr/fb_wdata are 0 whenever fb_wen=0.
- frame_start sampled high at edge k: ERASE occupies cycles k+1..k+NUM_BOIDS; each boid then takes 3 cycles (FETCH, WAIT, DRAW); done is high in cycle k+4*NUM_BOIDS+1 (k+65 for 16 boids) with no stalls. Each stalled cycle adds one.
- busy rises the cycle after frame_start and falls the cycle after done.

## Test plan
- First frame after reset, boid i at (10+i, 20): no ERASE writes, 16 DRAW writes with addr 20*640+10+i, data 42; done at k+65.
- Second frame, boids moved to (11+i, 20): 16 ERASE writes data 31 at old addresses, followed by 16 DRAW writes at new addresses; all erases precede all draws.
- Boid 3 at (639,479) -> write addr 307199; boid 4 at (640,0) -> no write that frame and no erase of it next frame.
- active held high for 5 cycles during ERASE at idx 2 -> fb_wen=0 for those cycles, idx holds at 2, done delayed to k+70.
- frame_start pulsed at k+10 and at the DONE cycle -> sequence unaffected, overrun_cnt=2; 300 extra pulses -> overrun_cnt saturates at 255.
- reset asserted during DRAW at idx 7 -> outputs 0 immediately, busy=0; the next frame performs no erases.
